// File: rtl/mux_rr_arbiter.sv
// Round-robin N:1 packet arbiter with a registered output beat; grant locked per packet.
// Optional MUX_RR_ARBITER_FIXED_PRIO_EN: pointer held at 0, giving strict low-index priority.
//
// state    | meaning
// S_IDLE   | no packet owned; arbitrate from the round-robin pointer
// S_LOCKED | packet in flight; only grant_idx may be accepted
module mux_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_data,
    input  logic [N-1:0]         req_last,
    output logic [N-1:0]         req_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IW = $clog2(N);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   w_ptr_nxt;
    logic            r_out_valid;
    logic [W-1:0]    r_out_data;
    logic            r_out_last;
    logic [IW-1:0]   r_grant;

    logic            w_load;
    logic            w_found;
    logic [IW-1:0]   w_win;
    logic [IW:0]     w_sum;
    logic [IW-1:0]   w_sel;
    logic            w_has;
    logic            w_accept;
    logic            w_sel_last;
    logic [N-1:0]    w_ready;

    function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] idx);
        if (idx == IW'(N - 1))
            return '0;
        return idx + IW'(1);
    endfunction

    assign w_load = !r_out_valid || out_ready;

    // Circular search starting at the pointer, wrapping by compare so N need not be a power of two.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N))
                w_sum = w_sum - (IW+1)'(N);
            if (!w_found && req_valid[w_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        w_sel      = (r_state == S_IDLE) ? w_win : r_grant;
        w_has      = (r_state == S_IDLE) ? w_found : req_valid[r_grant];
        w_accept   = rst_n && w_load && w_has;
        w_sel_last = req_last[w_sel];
        w_ready    = '0;
        if (w_accept)
            w_ready[w_sel] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        if (w_accept && w_sel_last) begin
            w_state_nxt = S_IDLE;
`ifdef MUX_RR_ARBITER_FIXED_PRIO_EN
            w_ptr_nxt   = '0;
`else
            w_ptr_nxt   = f_inc(w_sel);
`endif
        end else if (w_accept) begin
            w_state_nxt = S_LOCKED;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_grant     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            if (w_load)
                r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_data <= req_data[w_sel*W +: W];
                r_out_last <= w_sel_last;
                r_grant    <= w_sel;
            end
        end
    end

    assign req_ready = w_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign grant_idx = r_grant;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (N=4, W=8): reset, round-robin, lock, backpressure, reset mid-packet.
module tb_mux_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic [3:0]  rl;
    logic [3:0]  ready;
    logic        ov;
    logic [7:0]  od;
    logic        ol;
    logic        ordy;
    logic [1:0]  gi;

    int total = 0;
    int bad   = 0;

    mux_rr_arbiter #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (rv),
        .req_data  (rd),
        .req_last  (rl),
        .req_ready (ready),
        .out_valid (ov),
        .out_data  (od),
        .out_last  (ol),
        .out_ready (ordy),
        .grant_idx (gi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge; inputs change here, ready is checked 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rv    = 4'hF;
        rl    = 4'hF;
        rd    = 32'h13121110;
        ordy  = 1'b1;

        repeat (3) begin
            cyc();
            #1 chk("rst_ready", ready, 0);
            chk("rst_ov", ov, 0);
            chk("rst_od", od, 0);
            chk("rst_gi", gi, 0);
        end

        rst_n = 1'b1;
`ifdef MUX_RR_ARBITER_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) begin
            #1 chk("fp_ready", ready, 4'b0001);
            cyc();
            chk("fp_data", od, 8'h10);
            chk("fp_gi", gi, 0);
        end
        rv = 4'b1110;
        #1 chk("fp_ready1", ready, 4'b0010);
        cyc();
        chk("fp_data1", od, 8'h11);
        chk("fp_gi1", gi, 1);
`else
        // Single-beat packets from everyone: 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            #1 chk("rr_ready", ready, 32'd1 << (k % 4));
            cyc();
            chk("rr_data", od, 32'h10 + (k % 4));
            chk("rr_ov", ov, 1);
            chk("rr_gi", gi, k % 4);
        end
        rv = 4'b0000;
        cyc();
        chk("drain_ov", ov, 0);

        // Pointer is 1: requester 2 wins and locks out requester 0 until its last beat.
        rv = 4'b0101;
        rl = 4'b0000;
        rd = 32'h13A01110;
        #1 chk("lk_a0_ready", ready, 4'b0100);
        cyc();
        chk("lk_a0_data", od, 8'hA0);
        chk("lk_a0_gi", gi, 2);
        rd = 32'h13A11110;
        #1 chk("lk_a1_ready", ready, 4'b0100);
        cyc();
        chk("lk_a1_data", od, 8'hA1);
        rv = 4'b0001;
        for (int k = 0; k < 2; k++) begin
            #1 chk("lk_stall_ready", ready, 4'b0000);
            cyc();
            chk("lk_stall_ov", ov, 0);
            chk("lk_stall_gi", gi, 2);
        end
        rv = 4'b0101;
        rl = 4'b0100;
        rd = 32'h13A21110;
        #1 chk("lk_a2_ready", ready, 4'b0100);
        cyc();
        chk("lk_a2_data", od, 8'hA2);
        chk("lk_a2_last", ol, 1);
        rv = 4'b0001;
        rl = 4'b0001;
        #1 chk("lk_next_ready", ready, 4'b0001);
        cyc();
        chk("lk_next_data", od, 8'h10);
        chk("lk_next_gi", gi, 0);
        rv = 4'b0000;
        cyc();

        // Backpressure: pointer is 1, requester 1 alone.
        ordy = 1'b0;
        rv   = 4'b0010;
        rl   = 4'b0010;
        rd   = 32'h13121110;
        #1 chk("bp_first_ready", ready, 4'b0010);
        cyc();
        chk("bp_first_data", od, 8'h11);
        rd = 32'h13122110;
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_hold_ready", ready, 4'b0000);
            cyc();
            chk("bp_hold_data", od, 8'h11);
            chk("bp_hold_ov", ov, 1);
        end
        ordy = 1'b1;
        #1 chk("bp_resume_ready", ready, 4'b0010);
        cyc();
        chk("bp_resume_data", od, 8'h21);
        chk("bp_resume_ov", ov, 1);
        rv = 4'b0000;
        cyc();
        chk("bp_drain_ov", ov, 0);

        // Pointer is 2: requester 3 starts a multi-beat packet, then reset hits.
        rv = 4'b1000;
        rl = 4'b0000;
        rd = 32'h30121110;
        #1 chk("rm_b0_ready", ready, 4'b1000);
        cyc();
        chk("rm_b0_data", od, 8'h30);
        chk("rm_b0_gi", gi, 3);
        rst_n = 1'b0;
        rd    = 32'h31121110;
        cyc();
        chk("rm_rst_ov", ov, 0);
        chk("rm_rst_gi", gi, 0);
        rst_n = 1'b1;
        rv    = 4'b1001;
        #1 chk("rm_after_ready", ready, 4'b0001);
        cyc();
        chk("rm_after_data", od, 8'h10);
        chk("rm_after_gi", gi, 0);
        rv = 4'b0000;
        cyc();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
